// File: rtl/cla_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Purpose:
//   Feeds a wide operand pair to an external 4-bit carry-lookahead adder one
//   nibble per cycle, LSB nibble first. Each cycle the CLA sum nibble and
//   carry-out are registered, and the carry is chained into the next nibble.
//   The assembled result and final carry are then offered on an output
//   handshake.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds valid and its data stable until that edge. in_ready is
//   1 only in IDLE. out_valid is 1 only in DONE, and out_sum, out_cout and
//   out_ovf stay stable while out_ready is 0.
//
// Parameters:
//   NIBBLES   number of 4-bit slices per operand (2..8), WIDTH = 4*NIBBLES
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     operand handshake
//   in_a, in_b, in_cin    operands and carry-in for nibble 0
//   cla_a, cla_b, cla_cin nibble and carry driven to the external CLA (0 outside RUN)
//   cla_sum, cla_cout     combinational response of the external CLA
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     assembled sum and final carry (0 outside DONE)
//   out_ovf               two's-complement overflow (CLA_SEQ_OVF_EN only, else 0)
//   busy                  high in RUN or DONE
//   dbg_state             current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature macro: CLA_SEQ_OVF_EN
//   Defined   : out_ovf = carry-into-MSB ^ carry-out, valid in DONE only.
//   Undefined : out_ovf tied to 0.
// -----------------------------------------------------------------------------
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic [3:0]             cla_a,
  output logic [3:0]             cla_b,
  output logic                   cla_cin,
  input  logic [3:0]             cla_sum,
  input  logic                   cla_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IW    = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [WIDTH-1:0]  a_q,     a_d;
  logic [WIDTH-1:0]  b_q,     b_d;
  logic [WIDTH-1:0]  sum_q,   sum_d;
  logic              carry_q, carry_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = cla_sum;
        carry_d             = cla_cout;
        // idx stays on the last nibble when leaving RUN so it never
        // exceeds NIBBLES-1.
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // All outputs are decodes of registered state; results are gated so that
  // no partially built sum is visible outside DONE.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    out_sum   = (state_q == S_DONE) ? sum_q : '0;
    out_cout  = (state_q == S_DONE) ? carry_q : 1'b0;
    dbg_state = state_q;
    if (state_q == S_RUN) begin
      cla_a   = a_q[4*idx_q +: 4];
      cla_b   = b_q[4*idx_q +: 4];
      cla_cin = carry_q;
    end else begin
      cla_a   = 4'd0;
      cla_b   = 4'd0;
      cla_cin = 1'b0;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  // a^b^sum at the MSB recovers the carry into the MSB; XOR with carry-out
  // gives signed overflow.
  assign out_ovf = (state_q == S_DONE) &
                   (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_q[WIDTH-1] ^ carry_q);
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
module tb_cla_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  // ---------------- clock / reset / signals ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic [3:0]   cla_a, cla_b, cla_sum;
  logic         cla_cin, cla_cout;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf, busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  // External 4-bit adder the sequencer drives.
  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

  cla_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           vectors_applied = 0;
  int           miscompares     = 0;
  logic [W:0]   exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed overflow of a+b+cin from plain arithmetic.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W:0] full);
`ifdef CLA_SEQ_OVF_EN
    return (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_checks(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_cla"},       {cla_a, cla_b, cla_cin}, 0);
    check({tag, "_out_sum"},   out_sum,   0);
    check({tag, "_out_cout"},  out_cout,  0);
    check({tag, "_out_ovf"},   out_ovf,   0);
  endtask

  // ---------------- driver tasks ----------------
  // Starts one operation from IDLE, checks every RUN cycle, the DONE result,
  // the held output during stall cycles, and the return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int stall);
    logic [W:0]  full, got;
    logic [63:0] mask, lo;
    logic        exp_o;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_o = ref_ovf(a, b, full);
    exp_q.push_back(full);
    out_ready = (stall == 0);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      mask = (64'd1 << (4 * i)) - 64'd1;
      lo   = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
      check("run_cla_a",   cla_a,   (64'(a) >> (4 * i)) & 64'hF);
      check("run_cla_b",   cla_b,   (64'(b) >> (4 * i)) & 64'hF);
      check("run_cla_cin", cla_cin, (lo >> (4 * i)) & 64'd1);
      check("run_out_valid", out_valid, 0);
      check("run_in_ready",  in_ready,  0);
      check("run_busy",      busy,      1);
      if (i == 1) in_valid = 1'b1;  // must be ignored while busy
      @(posedge clk); #1;
    end
    got = exp_q.pop_front();
    check("done_out_valid", out_valid, 1);
    check("done_out_sum",   out_sum,   got[W-1:0]);
    check("done_out_cout",  out_cout,  got[W]);
    check("done_out_ovf",   out_ovf,   exp_o);
    check("done_cla",       {cla_a, cla_b, cla_cin}, 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready",  in_ready,  0);
      check("stall_out_sum",   out_sum,   got[W-1:0]);
      check("stall_out_cout",  out_cout,  got[W]);
      check("stall_out_ovf",   out_ovf,   exp_o);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle_checks("post");
  endtask

  // Starts an operation and asserts rst for 2 cycles, `at` cycles after the
  // accepting edge (at < N lands in RUN, at >= N in DONE with out_ready low).
  task automatic reset_abort(input logic [W-1:0] a, input logic [W-1:0] b, input int at);
    out_ready = 1'b0;
    in_a = a; in_b = b; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (at) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    idle_checks("abort1");
    @(posedge clk); #1;
    idle_checks("abort2");
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle_checks("por");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'hA5A5, 16'h5A5B, 1'b0, 3);

    reset_abort(16'h1111, 16'h2222, 2);
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    reset_abort(16'h3333, 16'h4444, N + 1);
    run_op(16'h0001, 16'h0001, 1'b0, 1);

    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0);

    for (int t = 0; t < 30; t++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
